// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes and
// access-size constants.
package ysyx_22040237_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // RISC-V load/store size and sign codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // log2 of the access size in bytes (funct3[1:0])
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int unsigned LANES = 8;

  // Byte-enable pattern of an access starting at lane 0
  function automatic logic [LANES-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_fmt.sv
// Combinational lane formatter for the LSU.
// Ports: off (byte offset in doubleword), funct3 (size/sign code),
//        store_data, rdata (inputs); wmask_c, wdata_c (store lanes),
//        load_data_c (aligned and extended load result), misaligned_c.
module ysyx_22040237_lsu_fmt
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]        off,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  wmask_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] load_data_c,
  output logic              misaligned_c
);

  logic [5:0]        bit_off;
  logic [DATA_W-1:0] shifted;

  assign bit_off = {off, 3'b000};

  // Lane placement for stores, lane extraction and extension for loads
  always_comb begin
    wmask_c      = LANES'(size_mask(funct3[1:0]) << off);
    wdata_c      = store_data << bit_off;
    shifted      = rdata >> bit_off;
    load_data_c  = shifted;
    misaligned_c = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        load_data_c = {{(DATA_W-8){~funct3[2] & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        load_data_c  = {{(DATA_W-16){~funct3[2] & shifted[15]}}, shifted[15:0]};
        misaligned_c = off[0];
      end
      SZ_W: begin
        load_data_c  = {{(DATA_W-32){~funct3[2] & shifted[31]}}, shifted[31:0]};
        misaligned_c = (off[1:0] != 2'b00);
      end
      default: begin
        load_data_c  = shifted;
        misaligned_c = (off != 3'b000);
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit between execute and writeback. Accepts one instruction at a
// time, runs a valid/ready request plus valid response data-memory transaction
// for loads and stores, and returns the formatted load result (0 for stores,
// exu_result for non-memory instructions).
// Ports: clk, rst (sync, active-high); in_valid/in_ready, mem_ren, mem_wen,
//        funct3, exu_result, store_data from execute; out_valid/out_ready,
//        out_rd_data, misaligned to writeback; dmem_req_* / dmem_rsp_* to
//        data memory.
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] exu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              misaligned,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [LANES-1:0]  dmem_req_wmask,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata
);

  lsu_state_e state;
  logic [2:0] off_q;
  logic [2:0] funct3_q;
  logic       is_load_q;

  logic [2:0]        off_sel;
  logic [2:0]        funct3_sel;
  logic [LANES-1:0]  wmask_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_data_c;
  logic              misaligned_c;

  // Formatter sees the live instruction while idle and the latched one after
  assign off_sel    = (state == LSU_IDLE) ? exu_result[2:0] : off_q;
  assign funct3_sel = (state == LSU_IDLE) ? funct3 : funct3_q;

  ysyx_22040237_lsu_fmt #(
    .DATA_W(DATA_W)
  ) u_fmt (
    .off          (off_sel),
    .funct3       (funct3_sel),
    .store_data   (store_data),
    .rdata        (dmem_rsp_rdata),
    .wmask_c      (wmask_c),
    .wdata_c      (wdata_c),
    .load_data_c  (load_data_c),
    .misaligned_c (misaligned_c)
  );

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LSU_IDLE;
      off_q          <= 3'b000;
      funct3_q       <= 3'b000;
      is_load_q      <= 1'b0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_rd_data    <= '0;
      misaligned     <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_wmask <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            off_q     <= exu_result[2:0];
            funct3_q  <= funct3;
            is_load_q <= mem_ren;
            if ((mem_ren || mem_wen) && misaligned_c) begin
              // Faulting access never reaches memory
              misaligned  <= 1'b1;
              out_valid   <= 1'b1;
              out_rd_data <= '0;
              state       <= LSU_DONE;
            end else if (mem_ren || mem_wen) begin
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= mem_wen;
              dmem_req_addr  <= {exu_result[ADDR_W-1:3], 3'b000};
              dmem_req_wdata <= wdata_c;
              dmem_req_wmask <= wmask_c;
              state          <= LSU_REQ;
            end else begin
              out_valid   <= 1'b1;
              out_rd_data <= DATA_W'(exu_result);
              state       <= LSU_DONE;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (dmem_rsp_valid) begin
            out_rd_data <= is_load_q ? load_data_c : '0;
            out_valid   <= 1'b1;
            state       <= LSU_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
            in_ready   <= 1'b1;
            state      <= LSU_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Randomised self-checking bench for ysyx_22040237_lsu with a behavioural
// model of the expected request fields and writeback result.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mem_ren;
  logic        mem_wen;
  logic [2:0]  funct3;
  logic [63:0] exu_result;
  logic [63:0] store_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rd_data;
  logic        misaligned;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;

  ysyx_22040237_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .funct3         (funct3),
    .exu_result     (exu_result),
    .store_data     (store_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd_data    (out_rd_data),
    .misaligned     (misaligned),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_wmask (dmem_req_wmask),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected transaction phase: 0 idle, 1 request, 2 awaiting response, 3 result
  int          phase  = 0;
  logic        chk_on = 1'b0;
  logic        exp_store;
  logic        exp_mis;
  logic        exp_we;
  logic [63:0] exp_addr;
  logic [63:0] exp_wdata;
  logic [7:0]  exp_wmask;
  logic [63:0] exp_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [63:0] addr);
    return (addr % 64'(nbytes(f3))) != 0;
  endfunction

  function automatic logic [7:0] m_wmask(input logic [2:0] f3, input logic [63:0] addr);
    int m;
    m = ((1 << nbytes(f3)) - 1) << (addr % 8);
    return 8'(m);
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [63:0] addr);
    return sd << (8 * (addr % 8));
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] rd);
    int          n;
    logic [63:0] v;
    logic [63:0] keep;
    n = nbytes(f3);
    v = rd >> (8 * (addr % 8));
    if (n == 8) keep = '1;
    else keep = (64'd1 << (8 * n)) - 64'd1;
    v = v & keep;
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~keep;
    return v;
  endfunction

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("in_ready", 64'(in_ready), 64'(phase == 0));
      chk("req_valid", 64'(dmem_req_valid), 64'(phase == 1));
      chk("out_valid", 64'(out_valid), 64'(phase == 3));
      chk("misaligned", 64'(misaligned), 64'(phase == 3 && exp_mis));
      if (phase == 1) begin
        chk("req_addr", dmem_req_addr, exp_addr);
        chk("req_we", 64'(dmem_req_we), 64'(exp_we));
        if (exp_store) begin
          chk("req_wdata", dmem_req_wdata, exp_wdata);
          chk("req_wmask", 64'(dmem_req_wmask), 64'(exp_wmask));
        end
      end
      if (phase == 3) chk("rd_data", out_rd_data, exp_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 non-memory, 1 load, 2 store
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sd, input logic [63:0] rd,
                         input int req_stall, input int rsp_delay, input int out_stall);
    exp_store = (kind == 2);
    exp_we    = (kind == 2);
    exp_mis   = (kind != 0) && m_misaligned(f3, addr);
    exp_addr  = addr & ~64'h7;
    exp_wdata = m_wdata(sd, addr);
    exp_wmask = m_wmask(f3, addr);
    if (kind == 0)     exp_rd = addr;
    else if (exp_mis)  exp_rd = 64'd0;
    else if (kind == 1) exp_rd = m_load(f3, addr, rd);
    else               exp_rd = 64'd0;

    in_valid   = 1'b1;
    mem_ren    = (kind == 1);
    mem_wen    = (kind == 2);
    funct3     = f3;
    exu_result = addr;
    store_data = sd;
    step();
    in_valid   = 1'b0;
    mem_ren    = 1'($urandom_range(0, 1));
    mem_wen    = ~mem_ren;
    exu_result = {$urandom, $urandom};
    store_data = {$urandom, $urandom};
    funct3     = 3'($urandom);
    phase      = (kind != 0 && !exp_mis) ? 1 : 3;

    if (phase == 1) begin
      for (int i = 0; i < req_stall; i++) begin
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rsp_rdata = {$urandom, $urandom};
        step();
      end
      dmem_rsp_valid = 1'b0;
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      phase = 2;
      for (int i = 0; i < rsp_delay; i++) step();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = rd;
      step();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = {$urandom, $urandom};
      phase = 3;
    end

    for (int i = 0; i < out_stall; i++) begin
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      dmem_req_ready = 1'($urandom_range(0, 1));
      step();
    end
    dmem_rsp_valid = 1'b0;
    dmem_req_ready = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    phase = 0;
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    funct3         = 3'd0;
    exu_result     = '0;
    store_data     = '0;
    out_ready      = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    exp_store = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_wmask = '0; exp_rd = '0;
    step();
    step();

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);
    chk("rst_we", 64'(dmem_req_we), 64'd0);
    chk("rst_addr", dmem_req_addr, 64'd0);
    chk("rst_wdata", dmem_req_wdata, 64'd0);
    chk("rst_wmask", 64'(dmem_req_wmask), 64'd0);
    chk("rst_rd_data", out_rd_data, 64'd0);

    // Model pinned by hand-computed values
    chk("model_lb", m_load(3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_lhu", m_load(3'b101, 64'h8000_0006, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);
    chk("model_sw_mask", 64'(m_wmask(3'b010, 64'h8000_0004)), 64'hF0);
    chk("model_sw_data", m_wdata(64'h1122_3344, 64'h8000_0004), 64'h1122_3344_0000_0000);
    chk("model_ld_mis", 64'(m_misaligned(3'b011, 64'h8000_0004)), 64'd1);
    chk("model_lh_ok", 64'(m_misaligned(3'b001, 64'h8000_0006)), 64'd0);

    rst = 1'b0;
    chk_on = 1'b1;
    step();

    // Directed cases from the test plan
    run_txn(1, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0);
    run_txn(1, 3'b101, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0, 0);
    run_txn(2, 3'b010, 64'h8000_0004, 64'h1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 0);
    run_txn(1, 3'b011, 64'h8000_0004, 64'd0, 64'd0, 0, 0, 0);
    run_txn(0, 3'b000, 64'h1234, 64'd0, 64'd0, 0, 0, 3);
    run_txn(2, 3'b011, 64'h8000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 4, 0, 0);

    // Reset while awaiting a response, then a late response
    exp_store = 1'b0; exp_we = 1'b0; exp_mis = 1'b0;
    exp_addr  = 64'h8000_0008;
    in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'b011;
    exu_result = 64'h8000_0008;
    step();
    in_valid = 1'b0;
    phase = 1;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    phase = 2;
    step();
    rst = 1'b1;
    phase = 0;
    step();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 64'h1111_2222_3333_4444;
    step();
    dmem_rsp_valid = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    step();
    step();

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      int          kind;
      logic [2:0]  f3;
      logic [63:0] addr;
      kind = $urandom_range(0, 2);
      if (kind == 1) f3 = 3'($urandom_range(0, 6));
      else f3 = 3'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr = addr & ~(64'(nbytes(f3)) - 64'd1);
      run_txn(kind, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        step();
      end
      dmem_rsp_valid = 1'b0;
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
